viterbi_ber_checker: RTL and testbench
======================================

# viterbi_ber_checker

Bit-error-rate checker that sits directly downstream of the Viterbi decoder in the encoder/channel/decoder loop. It taps the raw stream fed to the encoder as reference and the decoder output as data. It searches for the decoder's pipeline latency, locks onto it, and then counts compared bits and residual bit errors. It provides a pass/fail measure for each channel error-injection pattern.

## Interface
- MAX_LAT, 64: largest decoder latency searched, in clocks (≥1).
- LOCK_WIN, 32: consecutive matches needed to lock; also the loss-window length in compares.
- LOSS_THR, 8: mismatches within one loss window that drop lock (1..LOCK_WIN).
- CNT_W, 16: width of the bit and error counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- ref_i  in  1  reference bit, i.e. the encoder input, sampled every clock.
- dec_i  in  1  decoder output bit.
- dec_valid_i  in  1  dec_i is meaningful this clock; a compare happens only when this is high.
- clr_i  in  1  synchronous clear of bit_ct_o, err_ct_o and sat_o.
- locked_o  out  1  latency found; counting is active.
- latency_o  out  $clog2(MAX_LAT+1)  locked delay in clocks, 1..MAX_LAT.
- bit_ct_o  out  CNT_W  number of compares made while locked.
- err_ct_o  out  CNT_W  number of mismatches made while locked.
- err_o  out  1  one-clock pulse per locked mismatch.
- sat_o  out  1  sticky flag: a counter has hit its all-ones value.

## Operation
- History register hist[MAX_LAT-1:0] shifts every clock, regardless of valid: hist[0] <= ref_i, hist[k] <= hist[k-1].
- hist[k] is therefore ref_i from k+1 clocks earlier.
- Candidate index cand (0..MAX_LAT-1); the tested delay is cand+1.
- A compare is dec_i vs hist[cand], evaluated only on cycles where dec_valid_i=1.

State SEARCH (reset state):
- On a match: run_ct++.
- When the LOCK_WIN-th consecutive match occurs: go to LOCKED, latency_o <= cand+1, and clear win_ct and win_err.
- On a mismatch: run_ct <= 0 and cand <= (cand==MAX_LAT-1) ? 0 : cand+1.
- No counting in SEARCH; err_o stays 0.

State LOCKED:
- On each compare: bit_ct++, and on a mismatch err_ct++ plus an err_o pulse.
- win_ct counts compares 0..LOCK_WIN-1; win_err counts mismatches in the current window.
- When win_ct wraps, both win_ct and win_err reset to 0.
- Loss of lock: when a mismatch brings win_err to LOSS_THR, go to SEARCH. Set run_ct <= 0 and advance cand by one with wrap. locked_o falls.
- latency_o holds its last locked value while in SEARCH.
- bit_ct and err_ct are NOT cleared on loss or on relock; they accumulate across lock episodes.

Counters and clear:
- Counters saturate at 2^CNT_W-1; reaching that value sets sat_o, which is sticky.
- clr_i has priority. In the clr_i cycle, bit_ct, err_ct and sat_o become 0 and that cycle's compare is not counted. err_o still pulses, and lock tracking still runs.

Known limitation: a constant ref stream matches every candidate, so the checker locks at the first candidate tried. Benches must drive non-trivial data such as PRBS.

## Timing
- Reset values (asynchronous, immediate): locked_o=0, latency_o=0, bit_ct_o=0, err_ct_o=0, err_o=0, sat_o=0, state SEARCH, cand=0, run_ct=0, hist=0.
- Reset asserted mid-operation returns the block to these values. Search restarts at cand=0 after release.
- All outputs are registered and update on the edge after the deciding compare cycle:
  - locked_o rises one clock after the LOCK_WIN-th match.
  - err_o is high one clock after a locked mismatch.
  - Counters update on the same edge as err_o.
- Worst-case lock time, with dec_valid_i always 1 and a correct delay present: MAX_LAT×LOCK_WIN compares.
- Delays greater than MAX_LAT never lock.
- dec_valid_i=0 cycles freeze run_ct, win_ct and counters, but hist still shifts.

## Test plan
- PRBS-7 on ref_i, dec_i = ref_i delayed 10 clocks, dec_valid_i=1:
  - locked_o rises; latency_o=10.
  - After 1000 further compares: bit_ct_o=1000, err_ct_o=0.
- Locked as above, invert 3 isolated dec_i bits at least 40 compares apart:
  - 3 err_o pulses, err_ct_o=3, locked_o stays 1.
- Locked, invert 8 consecutive dec_i bits:
  - locked_o falls the clock after the 8th mismatch, and err_ct_o=8.
  - After cand wraps, the checker relocks with latency_o=10.
- Delay of 64 gives latency_o=64. Delay of 65 gives locked_o=0 after 10×64×32 clocks.
- CNT_W=4, locked, 20 clean compares:
  - bit_ct_o=15 and sat_o=1.
  - clr_i pulsed on a mismatching compare → bit_ct_o=0, err_ct_o=0, sat_o=0, and err_o still pulses.
- rst asserted for 1 clock while locked mid-stream:
  - All outputs are 0 before the next clock edge.
  - The checker relocks to 10 after release.

Source files
------------

// File: rtl/viterbi_ber_checker.sv
// BER checker behind a Viterbi decoder: finds the decoder latency against the
// encoder input stream, locks onto it, then counts compared bits and bit errors.
module viterbi_ber_checker #(
  parameter int MAX_LAT  = 64,
  parameter int LOCK_WIN = 32,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 16,
  localparam int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_i,
  input  logic             dec_i,
  input  logic             dec_valid_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic [LAT_W-1:0] latency_o,
  output logic [CNT_W-1:0] bit_ct_o,
  output logic [CNT_W-1:0] err_ct_o,
  output logic             err_o,
  output logic             sat_o
);

  localparam int CAND_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int WIN_W  = $clog2(LOCK_WIN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [MAX_LAT-1:0] hist;
  logic [CAND_W-1:0]  cand, cand_nxt, cand_inc;
  logic [WIN_W-1:0]   run_ct, run_nxt;
  logic [WIN_W-1:0]   win_ct, win_ct_nxt;
  logic [WIN_W-1:0]   win_err, win_err_nxt;
  logic [LAT_W-1:0]   lat_nxt;
  logic [CNT_W-1:0]   bit_nxt, err_nxt;
  logic               sat_nxt, err_pulse_nxt;
  logic               mism;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // hist[k] holds ref_i from k+1 clocks ago; it shifts regardless of dec_valid_i
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else     hist <= (hist << 1) | MAX_LAT'(ref_i);
  end

  assign mism     = dec_i ^ hist[cand];
  assign cand_inc = (cand == CAND_W'(MAX_LAT - 1)) ? '0 : cand + CAND_W'(1);

  always_comb begin
    state_nxt     = state;
    cand_nxt      = cand;
    run_nxt       = run_ct;
    win_ct_nxt    = win_ct;
    win_err_nxt   = win_err;
    lat_nxt       = latency_o;
    bit_nxt       = bit_ct_o;
    err_nxt       = err_ct_o;
    sat_nxt       = sat_o;
    err_pulse_nxt = 1'b0;
    if (dec_valid_i) begin
      case (state)
        SEARCH: begin
          if (!mism) begin
            if (run_ct == WIN_W'(LOCK_WIN - 1)) begin
              state_nxt   = LOCKED;
              lat_nxt     = LAT_W'(cand) + LAT_W'(1);
              win_ct_nxt  = '0;
              win_err_nxt = '0;
              run_nxt     = '0;
            end else begin
              run_nxt = run_ct + WIN_W'(1);
            end
          end else begin
            run_nxt  = '0;
            cand_nxt = cand_inc;
          end
        end
        LOCKED: begin
          err_pulse_nxt = mism;
          bit_nxt       = sat_inc(bit_ct_o);
          if (mism) err_nxt = sat_inc(err_ct_o);
          sat_nxt = sat_o | (&bit_nxt) | (&err_nxt);
          // Loss check precedes the window wrap so a threshold hit on the
          // window's last compare still drops lock.
          if (mism && (win_err + WIN_W'(1) == WIN_W'(LOSS_THR))) begin
            state_nxt = SEARCH;
            run_nxt   = '0;
            cand_nxt  = cand_inc;
          end else if (win_ct == WIN_W'(LOCK_WIN - 1)) begin
            win_ct_nxt  = '0;
            win_err_nxt = '0;
          end else begin
            win_ct_nxt  = win_ct + WIN_W'(1);
            win_err_nxt = win_err + WIN_W'(mism);
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
    if (clr_i) begin
      bit_nxt = '0;
      err_nxt = '0;
      sat_nxt = 1'b0;
    end
  end

  // Registered outputs: everything updates on the edge after the deciding compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      cand      <= '0;
      run_ct    <= '0;
      win_ct    <= '0;
      win_err   <= '0;
      locked_o  <= 1'b0;
      latency_o <= '0;
      bit_ct_o  <= '0;
      err_ct_o  <= '0;
      err_o     <= 1'b0;
      sat_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      run_ct    <= run_nxt;
      win_ct    <= win_ct_nxt;
      win_err   <= win_err_nxt;
      locked_o  <= (state_nxt == LOCKED);
      latency_o <= lat_nxt;
      bit_ct_o  <= bit_nxt;
      err_ct_o  <= err_nxt;
      err_o     <= err_pulse_nxt;
      sat_o     <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: PRBS-7 reference, delayed/corrupted decoder
// stream, checked every cycle against a behavioural model (two counter widths).
module tb_viterbi_ber_checker;

  localparam int MAX_LAT  = 64;
  localparam int LOCK_WIN = 32;
  localparam int LOSS_THR = 8;
  localparam int CNT_W    = 16;
  localparam int CNT_W4   = 4;
  localparam int LAT_W    = $clog2(MAX_LAT + 1);
  localparam int MX16     = (1 << CNT_W) - 1;
  localparam int MX4      = (1 << CNT_W4) - 1;

  logic              clk = 1'b0;
  logic              rst, ref_i, dec_i, dec_valid_i, clr_i;
  logic              locked_o, err_o, sat_o;
  logic [LAT_W-1:0]  latency_o;
  logic [CNT_W-1:0]  bit_ct_o, err_ct_o;
  logic              locked4, err_p4, sat4;
  logic [LAT_W-1:0]  latency4;
  logic [CNT_W4-1:0] bit4, err4;

  always #5 clk = ~clk;

  viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .LOCK_WIN(LOCK_WIN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ref_i(ref_i), .dec_i(dec_i), .dec_valid_i(dec_valid_i), .clr_i(clr_i),
    .locked_o(locked_o), .latency_o(latency_o), .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o),
    .err_o(err_o), .sat_o(sat_o));

  viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .LOCK_WIN(LOCK_WIN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W4)) dut4 (
    .clk(clk), .rst(rst), .ref_i(ref_i), .dec_i(dec_i), .dec_valid_i(dec_valid_i), .clr_i(clr_i),
    .locked_o(locked4), .latency_o(latency4), .bit_ct_o(bit4), .err_ct_o(err4),
    .err_o(err_p4), .sat_o(sat4));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: reference history as a queue of past bits
  bit m_q[$];
  int m_locked, m_lat, m_cand, m_run, m_wct, m_werr, m_errp;
  int m_bit, m_err, m_sat, m_bit4, m_err4, m_sat4;

  function automatic int sat_add(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_locked = 0; m_lat = 0; m_cand = 0; m_run = 0; m_wct = 0; m_werr = 0; m_errp = 0;
    m_bit = 0; m_err = 0; m_sat = 0; m_bit4 = 0; m_err4 = 0; m_sat4 = 0;
  endtask

  task automatic model_step();
    bit h, mm;
    h = (m_cand < m_q.size()) ? m_q[m_cand] : 1'b0;
    mm = (dec_i != h);
    m_errp = 0;
    if (dec_valid_i && !m_locked) begin
      if (!mm) begin
        m_run++;
        if (m_run == LOCK_WIN) begin
          m_locked = 1; m_lat = m_cand + 1; m_wct = 0; m_werr = 0; m_run = 0;
        end
      end else begin
        m_run = 0;
        m_cand = (m_cand + 1) % MAX_LAT;
      end
    end else if (dec_valid_i) begin
      m_errp = mm;
      m_bit  = sat_add(m_bit, MX16);
      m_bit4 = sat_add(m_bit4, MX4);
      if (mm) begin
        m_err  = sat_add(m_err, MX16);
        m_err4 = sat_add(m_err4, MX4);
        m_werr++;
      end
      if (mm && m_werr == LOSS_THR) begin
        m_locked = 0; m_run = 0;
        m_cand = (m_cand + 1) % MAX_LAT;
      end else begin
        m_wct++;
        if (m_wct == LOCK_WIN) begin m_wct = 0; m_werr = 0; end
      end
    end
    if (clr_i) begin
      m_bit = 0; m_err = 0; m_sat = 0; m_bit4 = 0; m_err4 = 0; m_sat4 = 0;
    end else begin
      if (m_bit == MX16 || m_err == MX16) m_sat = 1;
      if (m_bit4 == MX4 || m_err4 == MX4) m_sat4 = 1;
    end
    m_q.push_front(ref_i);
    if (m_q.size() > MAX_LAT) void'(m_q.pop_back());
  endtask

  // Per-cycle comparison of both DUTs against the model
  bit chk_en = 1'b0;
  int n_errp = 0;
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("locked", locked_o, m_locked);
      chk("latency", latency_o, m_lat);
      chk("bit_ct", bit_ct_o, m_bit);
      chk("err_ct", err_ct_o, m_err);
      chk("err_o", err_o, m_errp);
      chk("sat", sat_o, m_sat);
      chk("locked4", locked4, m_locked);
      chk("bit_ct4", bit4, m_bit4);
      chk("err_ct4", err4, m_err4);
      chk("sat4", sat4, m_sat4);
      if (err_o) n_errp++;
    end
  end

  // Stimulus: PRBS-7 reference; decoder stream is reference delayed D clocks
  logic [6:0] lfsr;
  bit         sp[$];
  int         D;
  bit         last_lc;

  task automatic drive(input bit vld, input bit inv, input bit clr);
    bit r;
    r = lfsr[6];
    @(negedge clk);
    rst         = 1'b0;
    ref_i       = r;
    dec_i       = ((D - 1 < sp.size()) ? sp[D-1] : 1'b0) ^ inv;
    dec_valid_i = vld;
    clr_i       = clr;
    @(posedge clk);
    last_lc = vld && (m_locked != 0);
    model_step();
    sp.push_front(r);
    if (sp.size() > 80) void'(sp.pop_back());
    lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_locked", locked_o, 0);
    chk("rst_latency", latency_o, 0);
    chk("rst_bit_ct", bit_ct_o, 0);
    chk("rst_err_ct", err_ct_o, 0);
    chk("rst_err_o", err_o, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_bit_ct4", bit4, 0);
  endtask

  task automatic wait_lock(input string name);
    int n = 0;
    while (!locked_o && n < MAX_LAT * LOCK_WIN * 3) begin
      drive($urandom_range(0, 99) < 85, 1'b0, 1'b0);
      #1;
      n++;
    end
    if (!locked_o) chk(name, 0, 1);
  endtask

  task automatic run_cmp(input int ncmp, input string name);
    int n = 0;
    int g = 0;
    while (n < ncmp && g < ncmp * 4) begin
      drive($urandom_range(0, 99) < 85, 1'b0, 1'b0);
      if (last_lc) n++;
      g++;
    end
    if (n < ncmp) chk(name, n, ncmp);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ref_i = 1'b0; dec_i = 1'b0; dec_valid_i = 1'b0; clr_i = 1'b0;
    model_reset();
    lfsr = 7'($urandom_range(1, 127));
    D = 10;
    #3;
    chk("init_locked", locked_o, 0);
    chk("init_latency", latency_o, 0);
    chk("init_bit_ct", bit_ct_o, 0);
    chk("init_sat", sat_o, 0);
    chk_en = 1'b1;

    // Lock onto delay 10, then count clean compares
    wait_lock("lock_d10");
    chk("lat_d10", latency_o, 10);
    run_cmp(20, "cmp20");
    chk("bit4_sat15", bit4, 15);
    chk("sat4_set", sat4, 1);
    chk("bit_20", bit_ct_o, 20);
    chk("sat16_clear", sat_o, 0);
    run_cmp(980, "cmp980");
    chk("bit_1000", bit_ct_o, 1000);
    chk("err_0", err_ct_o, 0);

    // Clear on a mismatching compare: counters zero, pulse still fires
    drive(1'b1, 1'b1, 1'b1);
    #1;
    chk("clr_bit", bit_ct_o, 0);
    chk("clr_err", err_ct_o, 0);
    chk("clr_sat4", sat4, 0);
    chk("clr_bit4", bit4, 0);
    chk("clr_err_o", err_o, 1);
    chk("clr_locked", locked_o, 1);

    // Three isolated errors
    drive(1'b1, 1'b0, 1'b0);
    #3;
    n_errp = 0;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(40, 60)) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
    end
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    #3;
    chk("iso_pulses", n_errp, 3);
    chk("iso_err_ct", err_ct_o, 3);
    chk("iso_locked", locked_o, 1);

    // Burst of 8 at a window start drops lock on the 8th
    drive(1'b1, 1'b0, 1'b1);
    for (int g = 0; g < 40 && m_wct != 0; g++) drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      #1;
      chk("burst_locked", locked_o, (i < 7) ? 1 : 0);
    end
    chk("burst_err_ct", err_ct_o, 8);
    wait_lock("relock_d10");
    chk("relock_lat", latency_o, 10);

    // Asynchronous reset while locked, then relock
    do_reset();
    wait_lock("rst_relock");
    chk("rst_relock_lat", latency_o, 10);

    // Largest delay
    do_reset();
    D = 64;
    wait_lock("lock_d64");
    chk("lat_d64", latency_o, 64);

    // Delay beyond the search range never locks
    do_reset();
    D = 65;
    repeat (10 * MAX_LAT * LOCK_WIN) drive(1'b1, 1'b0, 1'b0);
    #1;
    chk("d65_unlocked", locked_o, 0);
    chk("d65_latency", latency_o, 0);

    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
